// File: rtl/skid_pkg.sv
// rtl/skid_pkg.sv - shared state encoding for the skid buffer
package skid_pkg;

   // Number of words the buffer can hold (main + skid).
   localparam int unsigned SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } skid_state_e;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry registered skid buffer
// Handshake flags decode straight from the state flops so neither side sees a combinational path.
module skid_buffer
   import skid_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
);

   skid_state_e  state_q, state_d;
   logic [N-1:0] main_q, main_d;
   logic [N-1:0] skid_q, skid_d;
   logic         in_fire;
   logic         out_fire;

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (state_q != FULL);
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_d  = in_data;
               state_d = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Data words carry no reset; they are only meaningful while the state marks them valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_skid_buffer.sv
// tb/tb_skid_buffer.sv - scoreboard bench for skid_buffer
module tb_skid_buffer;

   localparam int N = 8;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   int n_cmp = 0;
   int n_bad = 0;
   int n_out = 0;
   logic [N-1:0] exp_q[$];

   skid_buffer #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: a word accepted at an edge must be visible one edge later, and at most two are held.
   always @(negedge clk) begin
      if (!reset) begin
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_in_ready", {31'd0, in_ready}, 32'd1);
         exp_q.delete();
      end else begin
         check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
         if (out_valid && exp_q.size() > 0)
            check("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
         if (in_valid && in_ready)
            exp_q.push_back(in_data);
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int n0;
      reset     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h99;
      out_ready = 1'b0;
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      step(); step();

      // first word is accepted on the first edge after release
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h3C;
      step();
      in_valid = 1'b0;
      in_data  = 8'hFF;
      check("first_latency_valid", {31'd0, out_valid}, 32'd1);
      check("first_latency_data", {24'd0, out_data}, 32'h3C);
      out_ready = 1'b1;
      step();
      check("first_drained", {31'd0, out_valid}, 32'd0);

      // streaming 0x01..0x10 with no bubbles
      n0 = n_out;
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = i[N-1:0];
         step();
         check("stream_data", {24'd0, out_data}, i);
      end
      in_valid = 1'b0;
      step();
      check("stream_count", n_out - n0, 32'd16);

      // backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA1;
      step();
      in_data   = 8'hA2;
      step();
      in_valid  = 1'b0;
      in_data   = 8'hEE;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_data", {24'd0, out_data}, 32'hA1);
      step(); step();
      check("bp_stable", {24'd0, out_data}, 32'hA1);
      out_ready = 1'b1;
      step();
      check("bp_ready_back", {31'd0, in_ready}, 32'd1);
      check("bp_second", {24'd0, out_data}, 32'hA2);
      step();
      check("bp_empty", {31'd0, out_valid}, 32'd0);

      // simultaneous in/out fire in ONE
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      step();
      in_data   = 8'h66;
      out_ready = 1'b1;
      check("sim_before", {24'd0, out_data}, 32'h55);
      step();
      in_valid = 1'b0;
      check("sim_after", {24'd0, out_data}, 32'h66);
      check("sim_one_ready", {31'd0, in_ready}, 32'd1);
      check("sim_one_valid", {31'd0, out_valid}, 32'd1);
      step();

      // reset while FULL
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hB1;
      step();
      in_data   = 8'hB2;
      step();
      in_valid  = 1'b0;
      check("full_before_rst", {31'd0, in_ready}, 32'd0);
      #1 reset = 1'b0;
      #1;
      check("async_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      reset     = 1'b1;
      out_ready = 1'b1;
      step(); step();
      check("no_stale", {31'd0, out_valid}, 32'd0);

      // random traffic
      for (int c = 0; c < 10000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(); step(); step();
      check("final_drain", {31'd0, out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter: N, default 8, data width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0); clears all state immediately, released synchronously by the system.
REQ-004 in_valid  input  1  upstream offers in_data this cycle.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  N  upstream data word.
REQ-007 out_valid  output  1  out_data holds a valid word.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  N  oldest buffered word.

Function
REQ-010 The input transfer (in_fire) SHALL occur when in_valid and in_ready are both high at a rising clk edge; the output transfer (out_fire) SHALL occur when out_valid and out_ready are both high.
REQ-011 Storage SHALL be two N-bit registers: main, which drives out_data, and skid, which holds the overflow word.
REQ-012 The FSM SHALL have three states: EMPTY (no words), ONE (main valid), FULL (main and skid valid).
REQ-013 out_valid SHALL equal (state != EMPTY) and in_ready SHALL equal (state != FULL); both are decoded directly from the state flops, with no combinational path from out_ready or in_valid.
REQ-014 EMPTY: on in_fire, load main with in_data and go to ONE; otherwise hold.
REQ-015 ONE: on in_fire with out_fire, load main with in_data and stay in ONE; on in_fire without out_fire, load skid with in_data and go to FULL; on out_fire without in_fire, go to EMPTY; otherwise hold.
REQ-016 FULL: in_fire is impossible; on out_fire, load main with skid and go to ONE; otherwise hold.
REQ-017 Latency SHALL be exactly 1 cycle from in_fire to the word appearing on out_data.
REQ-018 Throughput SHALL be one word per cycle with no bubbles while out_ready stays high.
REQ-019 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-020 Words SHALL leave the block in arrival order, with no loss and no duplication.
REQ-021 in_data SHALL be ignored whenever in_fire is low; out_ready SHALL be ignored when out_valid=0.
REQ-022 Data registers SHALL not be cleared on reset; their content is don't-care while the matching valid state bit is clear.

Reset
REQ-023 While reset=0, state SHALL be EMPTY, so out_valid=0 and in_ready=1.
REQ-024 Reset asserted mid-operation SHALL discard all buffered words asynchronously, with no partial transfer.
REQ-025 The first in_fire SHALL be possible at the first rising edge after reset deasserts.

Structure
REQ-026 The state typedef (EMPTY, ONE, FULL, 2-bit encoding) SHALL reside in the shared package skid_pkg.
REQ-027 The block SHALL be a single module with no sub-modules; one sequential process holds state and data, and one combinational process computes next-state.

Verification
REQ-028 Reset check: with reset=0, drive in_valid=1 -> out_valid=0 and in_ready=1; after release, the first word appears on out_data one cycle after in_fire.
REQ-029 Streaming: N=8, send 0x01..0x10 back-to-back with out_ready=1 -> 16 outputs in order on 16 consecutive cycles, 1-cycle latency, no bubbles.
REQ-030 Backpressure: send 0xA1, 0xA2 with out_ready=0 -> state FULL, in_ready=0, out_data=0xA1 stable; raise out_ready -> 0xA1 then 0xA2 output, in_ready returns to 1 one cycle after the first out_fire.
REQ-031 Simultaneous: in state ONE holding 0x55, in_fire 0x66 together with out_fire -> 0x55 accepted and out_data=0x66 next cycle, state stays ONE.
REQ-032 Mid-operation reset: in state FULL, pulse reset=0 -> out_valid=0 immediately and in_ready=1, and no stale word is emitted after release.
REQ-033 Random: 10k cycles of random in_valid and out_ready with a scoreboard -> order preserved, no loss, and out_data stable under stall.
